wb_stage_lsq: RTL
=================

Name: wb_stage_lsq

Overview:
Parametrised write-back stage that supersedes the fixed single-cycle write-back. It accepts retiring instructions from the memory stage over a valid/ready handshake and issues loads to data memory over a request/response handshake with variable latency. It extracts and extends load data by byte lane, and owns the integer register file with write-through bypass read ports for decode. It also produces a registered retire trace and an instret counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
REG_COUNT, 32, number of architectural registers; AW = $clog2(REG_COUNT).
RD_PORTS, 2, number of register-file read ports.
CNT_W, 64, instret counter width.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
in_valid_i  in  1  memory stage presents a retiring instruction.
in_ready_o  out  1  stage can accept an instruction.
in_pc_i  in  XLEN  pc of the instruction.
in_instr_i  in  32  instruction word.
in_rd_we_i  in  1  instruction writes rd.
in_alu_i  in  XLEN  ALU result, or effective address for loads.
ld_req_valid_o  out  1  load request valid.
ld_req_ready_i  in  1  data memory accepts the request.
ld_req_addr_o  out  XLEN  word-aligned load address (low log2(XLEN/8) bits zero).
ld_rsp_valid_i  in  1  load data valid.
ld_rsp_data_i  in  XLEN  raw aligned word.
rd_addr_i  in  RD_PORTS*AW  packed read addresses.
rd_data_o  out  RD_PORTS*XLEN  packed read data, combinational.
misalign_o  out  1  one-cycle pulse on a misaligned or illegal load.
retire_valid_o  out  1  one-cycle retire pulse.
retire_pc_o, retire_instr_o  out  XLEN, 32  retired pc and instruction word.
retire_rd_o  out  AW  destination register.
retire_data_o  out  XLEN  value written (0 if nothing written).
instret_o  out  CNT_W  retired-instruction count.
busy_o  out  1  high while state is not S_IDLE.

Behaviour:
- Reset values: state S_IDLE; all registers 0; every output 0 except in_ready_o = 1; instret_o = 0.
- FSM states: S_IDLE, S_LD_REQ, S_LD_WAIT.
- in_ready_o = 1 only in S_IDLE.
- S_IDLE, accepted instruction is not a load (opcode != 0000011):
  - Computes write data: JAL/JALR write pc+4 (mod 2^XLEN); all others write in_alu_i.
  - Register file is written at the same rising edge when in_rd_we_i = 1 and rd != 0.
  - Retire pulse follows one cycle later; stays in S_IDLE, so back-to-back throughput is 1 instruction per cycle.
- S_IDLE, accepted instruction is a load: pc, instr, address and rd_we are latched; next state S_LD_REQ.
- S_LD_REQ: ld_req_valid_o = 1 with a stable address until ld_req_ready_i = 1, then S_LD_WAIT. ld_rsp_valid_i is ignored in this state.
- S_LD_WAIT: on ld_rsp_valid_i, lane offset = addr[log2(XLEN/8)-1:0]; selected bytes = rsp >> (8*offset).
  - funct3 000 LB sign-extends byte; 100 LBU zero-extends.
  - 001 LH sign-extends half; 101 LHU zero-extends; offset must be even.
  - 010 LW takes a word; offset must be a multiple of 4. For XLEN=64, LW sign-extends and 110 LWU zero-extends.
  - 011 LD exists only when XLEN=64; offset must be 0.
  - Register write happens at the response edge, then next state S_IDLE; the next instruction is accepted one cycle later.
- Misaligned offset or illegal funct3: detected at the response edge; no register write; misalign_o pulses one cycle later together with retire_valid_o; retire_data_o = 0.
- rd == 0: never written. Reads of x0 return 0, including on bypass.
- Read ports: array read; if a write occurs this cycle to the same nonzero address, the port returns the write data (write-through).
- Retire outputs: registered one cycle after the write edge; retire_valid_o is high for exactly 1 cycle.
- instret_o: increments on each retire pulse; wraps at 2^CNT_W.
- Reset in any state: back to S_IDLE at that edge; a pending load is abandoned with no write and no retire; a late ld_rsp_valid_i in S_IDLE is ignored; ld_req_valid_o is 0 after the edge.

Decomposition:
- Package wb_pkg: opcode constants (LOAD, JAL, JALR); load funct3 encodings; state_e enum; function lane_offset_w(XLEN).
- Sub-module wb_load_align (combinational).
  - Inputs: raw data, offset, funct3. Outputs: extended data, illegal flag.
  - Parameterised by XLEN.

Test Plan:
- Reset for 2 cycles -> in_ready_o = 1, all rd_data_o = 0, instret_o = 0, ld_req_valid_o = 0.
- ADD rd=5, alu=0x12345678, rd_addr_i[0]=5 in the same cycle -> rd_data_o[0] = 0x12345678 (bypass); retire pulse next cycle; a write to rd=0 leaves x0 = 0.
- JAL rd=1, pc=0x00000100 -> x1 = 0x00000104; pc=0xFFFFFFFC -> x1 = 0x00000000 (wrap).
- Response data 0x80FF1234:
  - LB at addr 0x1003 -> 0xFFFFFF80; LBU at 0x1003 -> 0x00000080.
  - LH at addr 0x1002 -> 0xFFFF80FF; LHU at 0x1002 -> 0x000080FF.
- Load with ld_req_ready_i low for 3 cycles and response 4 cycles after the request handshake -> in_ready_o low throughout; a held second instruction is accepted the cycle after the response; no register write before the response edge.
- LW at addr 0x1002 -> misalign_o pulse, no write, retire_data_o = 0, instret_o +1. Reset asserted in S_LD_WAIT, then response -> no write, no retire.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants, FSM state type and lane helper for the write-back stage.
package wb_pkg;

   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LD_REQ  = 2'd1,
      S_LD_WAIT = 2'd2
   } state_e;

   // Number of address bits that select a byte lane within one XLEN word.
   function automatic int lane_offset_w(input int xlen);
      return $clog2(xlen / 8);
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// Byte-lane extraction and sign/zero extension of a raw load word.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]                  raw_i,
   input  logic [lane_offset_w(XLEN)-1:0]   offset_i,
   input  logic [2:0]                       funct3_i,
   output logic [XLEN-1:0]                  data_o,
   output logic                             illegal_o
);

   logic [XLEN-1:0] shifted;

   assign shifted = raw_i >> {offset_i, 3'b000};

   always_comb begin
      data_o    = '0;
      illegal_o = 1'b0;
      case (funct3_i)
         F3_LB:  data_o = XLEN'($signed(shifted[7:0]));
         F3_LBU: data_o = XLEN'(shifted[7:0]);
         F3_LH: begin
            illegal_o = offset_i[0];
            data_o    = XLEN'($signed(shifted[15:0]));
         end
         F3_LHU: begin
            illegal_o = offset_i[0];
            data_o    = XLEN'(shifted[15:0]);
         end
         F3_LW: begin
            illegal_o = (offset_i[1:0] != 2'b00);
            data_o    = XLEN'($signed(shifted[31:0]));
         end
         F3_LWU: begin
            illegal_o = (XLEN != 64) || (offset_i[1:0] != 2'b00);
            data_o    = XLEN'(shifted[31:0]);
         end
         F3_LD: begin
            illegal_o = (XLEN != 64) || (offset_i != '0);
            data_o    = shifted;
         end
         default: illegal_o = 1'b1;
      endcase
      // Illegal accesses never expose partial data.
      if (illegal_o) begin
         data_o = '0;
      end
   end

endmodule

// File: rtl/wb_stage_lsq.sv
// Write-back stage: retires instructions, issues variable-latency loads,
// owns the register file with write-through read ports and the retire trace.
module wb_stage_lsq
   import wb_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32,
   parameter int RD_PORTS  = 2,
   parameter int CNT_W     = 64,
   localparam int AW       = $clog2(REG_COUNT)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [XLEN-1:0]          in_pc_i,
   input  logic [31:0]              in_instr_i,
   input  logic                     in_rd_we_i,
   input  logic [XLEN-1:0]          in_alu_i,
   output logic                     ld_req_valid_o,
   input  logic                     ld_req_ready_i,
   output logic [XLEN-1:0]          ld_req_addr_o,
   input  logic                     ld_rsp_valid_i,
   input  logic [XLEN-1:0]          ld_rsp_data_i,
   input  logic [RD_PORTS*AW-1:0]   rd_addr_i,
   output logic [RD_PORTS*XLEN-1:0] rd_data_o,
   output logic                     misalign_o,
   output logic                     retire_valid_o,
   output logic [XLEN-1:0]          retire_pc_o,
   output logic [31:0]              retire_instr_o,
   output logic [AW-1:0]            retire_rd_o,
   output logic [XLEN-1:0]          retire_data_o,
   output logic [CNT_W-1:0]         instret_o,
   output logic                     busy_o
);

   localparam int OW = lane_offset_w(XLEN);

   state_e            state_q;
   logic [XLEN-1:0]   pc_q, addr_q;
   logic [31:0]       instr_q;
   logic              rdWe_q;
   logic [XLEN-1:0]   regs_q [REG_COUNT];
   logic              retireValid_q, misalign_q;
   logic [XLEN-1:0]   retirePc_q, retireData_q;
   logic [31:0]       retireInstr_q;
   logic [AW-1:0]     retireRd_q;
   logic [CNT_W-1:0]  instret_q, instret_d;

   logic              inIsLoad, inIsLink;
   logic [XLEN-1:0]   alignData;
   logic              alignIllegal;
   logic              wrEn;
   logic [AW-1:0]     wrAddr;
   logic [XLEN-1:0]   wrData;

   assign inIsLoad  = (in_instr_i[6:0] == OP_LOAD);
   assign inIsLink  = (in_instr_i[6:0] == OP_JAL) || (in_instr_i[6:0] == OP_JALR);
   assign instret_d = instret_q + CNT_W'(1);

   wb_load_align #(.XLEN(XLEN)) u_align (
      .raw_i     (ld_rsp_data_i),
      .offset_i  (addr_q[OW-1:0]),
      .funct3_i  (instr_q[14:12]),
      .data_o    (alignData),
      .illegal_o (alignIllegal)
   );

   // Single register-file write port shared by the ALU path and load responses.
   always_comb begin
      wrEn   = 1'b0;
      wrAddr = AW'(in_instr_i[11:7]);
      wrData = inIsLink ? (in_pc_i + XLEN'(4)) : in_alu_i;
      if (state_q == S_IDLE && in_valid_i && !inIsLoad) begin
         wrEn = in_rd_we_i && (in_instr_i[11:7] != 5'd0);
      end else if (state_q == S_LD_WAIT && ld_rsp_valid_i) begin
         wrAddr = AW'(instr_q[11:7]);
         wrData = alignData;
         wrEn   = rdWe_q && (instr_q[11:7] != 5'd0) && !alignIllegal;
      end
      if (rst_i) begin
         wrEn = 1'b0;
      end
   end

   for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr_i[p*AW +: AW];
      assign rd_data_o[p*XLEN +: XLEN] = (ra == '0) ? '0 :
                                         (wrEn && wrAddr == ra) ? wrData : regs_q[ra];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         addr_q        <= '0;
         instr_q       <= '0;
         rdWe_q        <= 1'b0;
         retireValid_q <= 1'b0;
         misalign_q    <= 1'b0;
         retirePc_q    <= '0;
         retireInstr_q <= '0;
         retireRd_q    <= '0;
         retireData_q  <= '0;
         instret_q     <= '0;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         retireValid_q <= 1'b0;
         misalign_q    <= 1'b0;
         if (wrEn) begin
            regs_q[wrAddr] <= wrData;
         end
         case (state_q)
            S_IDLE: begin
               if (in_valid_i && inIsLoad) begin
                  pc_q    <= in_pc_i;
                  instr_q <= in_instr_i;
                  addr_q  <= in_alu_i;
                  rdWe_q  <= in_rd_we_i;
                  state_q <= S_LD_REQ;
               end else if (in_valid_i) begin
                  retireValid_q <= 1'b1;
                  retirePc_q    <= in_pc_i;
                  retireInstr_q <= in_instr_i;
                  retireRd_q    <= AW'(in_instr_i[11:7]);
                  retireData_q  <= wrEn ? wrData : '0;
                  instret_q     <= instret_d;
               end
            end
            S_LD_REQ: begin
               if (ld_req_ready_i) begin
                  state_q <= S_LD_WAIT;
               end
            end
            S_LD_WAIT: begin
               if (ld_rsp_valid_i) begin
                  retireValid_q <= 1'b1;
                  misalign_q    <= alignIllegal;
                  retirePc_q    <= pc_q;
                  retireInstr_q <= instr_q;
                  retireRd_q    <= AW'(instr_q[11:7]);
                  retireData_q  <= wrEn ? wrData : '0;
                  instret_q     <= instret_d;
                  state_q       <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o     = (state_q == S_IDLE);
   assign busy_o         = (state_q != S_IDLE);
   assign ld_req_valid_o = (state_q == S_LD_REQ);
   assign ld_req_addr_o  = {addr_q[XLEN-1:OW], {OW{1'b0}}};
   assign misalign_o     = misalign_q;
   assign retire_valid_o = retireValid_q;
   assign retire_pc_o    = retirePc_q;
   assign retire_instr_o = retireInstr_q;
   assign retire_rd_o    = retireRd_q;
   assign retire_data_o  = retireData_q;
   assign instret_o      = instret_q;

endmodule
